// File: rtl/wait_controller.sv
// wait_controller: multi-cycle instruction sequencer with a bounded memory wait and sticky timeout fault.
// Optional interrupt entry state and irq/irq_ack ports are enabled by defining WAITCTL_IRQ_EN.
module wait_controller #(
   parameter int         TIMEOUT  = 15,
   parameter int         CNT_W    = 4,
   parameter logic [3:0] LINK_REG = 4'hF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] instruction,
   input  logic        mem_ready,
`ifdef WAITCTL_IRQ_EN
   input  logic        irq,
   output logic        irq_ack,
`endif
   output logic [3:0]  oper,
   output logic [3:0]  func,
   output logic [3:0]  cond,
   output logic [7:0]  immediate,
   output logic [3:0]  dstaddr,
   output logic [3:0]  srcaddr,
   output logic        alusrca,
   output logic        alusrcb,
   output logic        sign_ext_imm,
   output logic        memread,
   output logic        memwrite,
   output logic        regwrite,
   output logic        pcwrite,
   output logic [1:0]  regsrc,
   output logic [1:0]  pcaddrsrc,
   output logic        busy,
   output logic        fault
);

`ifdef WAITCTL_IRQ_EN
   typedef enum logic [2:0] {BOOT, DECODE, CALC, MEMWAIT, LOAD, FAULT, IRQ} state_t;
`else
   typedef enum logic [2:0] {BOOT, DECODE, CALC, MEMWAIT, LOAD, FAULT} state_t;
`endif

   state_t           state, nxt;
   logic [CNT_W-1:0] cnt;
   logic             is_load, is_store, no_wb, in_irq;

   assign oper      = instruction[15:12];
   assign func      = instruction[7:4];
   assign immediate = instruction[7:0];
   assign srcaddr   = instruction[3:0];
   assign cond      = (oper == 4'h4 && func == 4'hD) ? instruction[3:0] : func;

   assign is_load  = oper == 4'h4 && func == 4'h0;
   assign is_store = oper == 4'h4 && func == 4'h4;

`ifdef WAITCTL_IRQ_EN
   assign in_irq = state == IRQ;
`else
   assign in_irq = 1'b0;
`endif

   // Interrupt entry writes the return link into a fixed register.
   assign dstaddr = in_irq ? LINK_REG : instruction[11:8];

   assign alusrca      = !(oper == 4'hC || (oper == 4'h4 && (func == 4'h0 || func == 4'h8)));
   assign alusrcb      = (|oper[1:0]) || (oper == 4'h8 && func[3:2] == 2'b00);
   assign sign_ext_imm = ((oper[3:2] == 2'b01 || oper[3:2] == 2'b10) && (|oper[1:0]))
                         || oper == 4'hC || oper == 4'hE;
   assign regsrc       = (in_irq || (oper == 4'h4 && func == 4'h8)) ? 2'b01 :
                         is_load ? 2'b10 : 2'b00;

   assign no_wb = oper == 4'hB || oper == 4'hC
                  || (oper == 4'h0 && (func == 4'h0 || func == 4'hB))
                  || (oper == 4'h4 && (func == 4'h0 || func == 4'h4 || func == 4'hC));

   assign busy      = state == MEMWAIT;
   assign fault     = state == FAULT;
   assign pcaddrsrc = {!pcwrite, (state == BOOT) ? 1'b0 : !alusrca};

   always_comb begin
      nxt      = state;
      memread  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
      pcwrite  = 1'b0;
`ifdef WAITCTL_IRQ_EN
      irq_ack  = 1'b0;
`endif
      case (state)
         BOOT: nxt = DECODE;
`ifdef WAITCTL_IRQ_EN
         DECODE: nxt = irq ? IRQ : CALC;
         IRQ: begin
            regwrite = 1'b1;
            pcwrite  = 1'b1;
            irq_ack  = 1'b1;
            nxt      = DECODE;
         end
`else
         DECODE: nxt = CALC;
`endif
         CALC: begin
            memread  = is_load;
            memwrite = is_store;
            regwrite = !no_wb;
            pcwrite  = is_store ? mem_ready : !is_load;
            nxt      = (is_load && mem_ready) ? LOAD :
                       ((is_load || is_store) && !mem_ready) ? MEMWAIT : DECODE;
         end
         MEMWAIT: begin
            memread  = is_load;
            memwrite = is_store;
            pcwrite  = is_store && mem_ready;
            // A completing access wins over a timeout on the same cycle.
            nxt      = mem_ready ? (is_load ? LOAD : DECODE) :
                       (cnt >= CNT_W'(TIMEOUT - 1)) ? FAULT : MEMWAIT;
         end
         LOAD: begin
            regwrite = 1'b1;
            pcwrite  = 1'b1;
            nxt      = DECODE;
         end
         FAULT: nxt = FAULT;
         default: nxt = BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= BOOT;
         cnt   <= '0;
      end else begin
         state <= nxt;
         cnt   <= (nxt == CALC) ? '0 :
                  (state == MEMWAIT && !mem_ready && cnt < CNT_W'(TIMEOUT)) ? cnt + CNT_W'(1) : cnt;
      end
   end

endmodule

// File: tb/tb_wait_controller.sv
// tb_wait_controller: directed scoreboard bench for wait_controller; covers the interrupt path when WAITCTL_IRQ_EN is defined.
module tb_wait_controller;

   logic        clk, rst, mem_ready;
   logic [15:0] instruction;
   logic [3:0]  oper, func, cond, dstaddr, srcaddr;
   logic [7:0]  immediate;
   logic        alusrca, alusrcb, sign_ext_imm, memread, memwrite, regwrite, pcwrite, busy, fault;
   logic [1:0]  regsrc, pcaddrsrc;
`ifdef WAITCTL_IRQ_EN
   logic        irq, irq_ack;
`endif

   int checks = 0;
   int errors = 0;

   logic [9:0] exp_q[$];
   string      tag_q[$];
   logic [9:0] obs;

   wait_controller dut (
      .clk(clk), .rst(rst), .instruction(instruction), .mem_ready(mem_ready),
`ifdef WAITCTL_IRQ_EN
      .irq(irq), .irq_ack(irq_ack),
`endif
      .oper(oper), .func(func), .cond(cond), .immediate(immediate),
      .dstaddr(dstaddr), .srcaddr(srcaddr), .alusrca(alusrca), .alusrcb(alusrcb),
      .sign_ext_imm(sign_ext_imm), .memread(memread), .memwrite(memwrite),
      .regwrite(regwrite), .pcwrite(pcwrite), .regsrc(regsrc), .pcaddrsrc(pcaddrsrc),
      .busy(busy), .fault(fault)
   );

   assign obs = {regwrite, pcwrite, memread, memwrite, regsrc, pcaddrsrc, busy, fault};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [9:0] x(input logic rw, pw, mr, mw, input logic [1:0] rs, pa,
                                    input logic b, f);
      return {rw, pw, mr, mw, rs, pa, b, f};
   endfunction

   // Drive one cycle away from the active edge, queue its expectation, then score it.
   task automatic cyc(input logic r, input logic [15:0] ins, input logic rdy,
                      input string tag, input logic [9:0] e);
      logic [9:0] want;
      string      t;
      @(negedge clk);
      rst         = r;
      instruction = ins;
      mem_ready   = rdy;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      #1;
      want = exp_q.pop_front();
      t    = tag_q.pop_front();
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", t, obs, want);
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, want);
      end
   endtask

   task automatic dec(input logic [15:0] ins, input logic [3:0] c, input logic sx, a, b,
                      input logic [1:0] rs);
      instruction = ins;
      #1;
      chk($sformatf("dec_%h", ins), {cond, sx ^ sign_ext_imm, a ^ alusrca, b ^ alusrcb, regsrc[0]},
          {c, 3'b000, rs[0]});
      chk($sformatf("dec_rs_%h", ins), {6'd0, regsrc}, {6'd0, rs});
   endtask

   initial begin
      rst         = 1'b0;
      instruction = 16'h0355;
      mem_ready   = 1'b0;
`ifdef WAITCTL_IRQ_EN
      irq         = 1'b0;
`endif
      repeat (2) @(posedge clk);
      cyc(0, 16'h0355, 0, "boot_rst", x(0,0,0,0,2'b00,2'b10,0,0));

      instruction = 16'h4144;
      #1;
      chk("fields_oper_func", {oper, func}, 8'h44);
      chk("fields_dst_src", {dstaddr, srcaddr}, 8'h14);
      chk("fields_imm", immediate, 8'h44);
      dec(16'h4144, 4'h4, 0, 1, 0, 2'b00);
      dec(16'h42D3, 4'h3, 0, 1, 0, 2'b00);
      dec(16'h5000, 4'h0, 1, 1, 1, 2'b00);
      dec(16'h4207, 4'h0, 0, 0, 0, 2'b10);
      dec(16'hC000, 4'h0, 1, 0, 0, 2'b00);
      dec(16'h8040, 4'h4, 0, 1, 0, 2'b00);
      dec(16'h8000, 4'h0, 0, 1, 1, 2'b00);
      dec(16'h4080, 4'h8, 0, 0, 0, 2'b01);

      cyc(1, 16'h0355, 0, "boot", x(0,0,0,0,2'b00,2'b10,0,0));
      cyc(1, 16'h0355, 0, "decode", x(0,0,0,0,2'b00,2'b10,0,0));
      cyc(1, 16'h0355, 0, "calc_add", x(1,1,0,0,2'b00,2'b00,0,0));

      cyc(1, 16'h4207, 1, "ld_decode", x(0,0,0,0,2'b10,2'b11,0,0));
      cyc(1, 16'h4207, 1, "ld_calc", x(0,0,1,0,2'b10,2'b11,0,0));
      cyc(1, 16'h4207, 0, "ld_load", x(1,1,0,0,2'b10,2'b01,0,0));

      cyc(1, 16'h4144, 0, "st_decode", x(0,0,0,0,2'b00,2'b10,0,0));
      cyc(1, 16'h4144, 0, "st_calc", x(0,0,0,1,2'b00,2'b10,0,0));
      cyc(1, 16'h4144, 0, "st_wait1", x(0,0,0,1,2'b00,2'b10,1,0));
      cyc(1, 16'h4144, 0, "st_wait2", x(0,0,0,1,2'b00,2'b10,1,0));
      cyc(1, 16'h4144, 1, "st_ready", x(0,1,0,1,2'b00,2'b00,1,0));

      cyc(1, 16'h4207, 0, "ld2_decode", x(0,0,0,0,2'b10,2'b11,0,0));
      cyc(1, 16'h4207, 0, "ld2_calc", x(0,0,1,0,2'b10,2'b11,0,0));
      for (int i = 0; i < 14; i++) cyc(1, 16'h4207, 0, "ld2_wait", x(0,0,1,0,2'b10,2'b11,1,0));
      cyc(1, 16'h4207, 1, "ld2_ready_at_limit", x(0,0,1,0,2'b10,2'b11,1,0));
      cyc(1, 16'h4207, 0, "ld2_load", x(1,1,0,0,2'b10,2'b01,0,0));

      cyc(1, 16'h4207, 0, "to_decode", x(0,0,0,0,2'b10,2'b11,0,0));
      cyc(1, 16'h4207, 0, "to_calc", x(0,0,1,0,2'b10,2'b11,0,0));
      for (int i = 0; i < 15; i++) cyc(1, 16'h4207, 0, "to_wait", x(0,0,1,0,2'b10,2'b11,1,0));
      cyc(1, 16'h4207, 1, "to_fault", x(0,0,0,0,2'b10,2'b11,0,1));
      cyc(1, 16'h4207, 1, "to_fault_hold", x(0,0,0,0,2'b10,2'b11,0,1));
      cyc(0, 16'h4207, 0, "to_fault_rst_low", x(0,0,0,0,2'b10,2'b11,0,1));
      cyc(0, 16'h4207, 0, "to_boot", x(0,0,0,0,2'b10,2'b10,0,0));

      cyc(1, 16'h4207, 0, "mr_boot", x(0,0,0,0,2'b10,2'b10,0,0));
      cyc(1, 16'h4207, 0, "mr_decode", x(0,0,0,0,2'b10,2'b11,0,0));
      cyc(1, 16'h4207, 0, "mr_calc", x(0,0,1,0,2'b10,2'b11,0,0));
      cyc(0, 16'h4207, 0, "mr_wait_rst_low", x(0,0,1,0,2'b10,2'b11,1,0));
      cyc(0, 16'h4207, 0, "mr_boot_after", x(0,0,0,0,2'b10,2'b10,0,0));

`ifdef WAITCTL_IRQ_EN
      cyc(1, 16'h0355, 0, "irq_boot", x(0,0,0,0,2'b00,2'b10,0,0));
      irq = 1'b1;
      cyc(1, 16'h0355, 0, "irq_decode", x(0,0,0,0,2'b00,2'b10,0,0));
      cyc(1, 16'h0355, 0, "irq_state", x(1,1,0,0,2'b01,2'b00,0,0));
      chk("irq_ack", {7'd0, irq_ack}, 8'h01);
      chk("irq_link", {4'd0, dstaddr}, 8'h0F);
      irq = 1'b0;
      cyc(1, 16'h0355, 0, "irq_ret_decode", x(0,0,0,0,2'b00,2'b10,0,0));
      cyc(1, 16'h0355, 0, "irq_ret_calc", x(1,1,0,0,2'b00,2'b00,0,0));
      cyc(1, 16'h4144, 0, "irqmw_decode", x(0,0,0,0,2'b00,2'b10,0,0));
      cyc(1, 16'h4144, 0, "irqmw_calc", x(0,0,0,1,2'b00,2'b10,0,0));
      irq = 1'b1;
      cyc(1, 16'h4144, 0, "irqmw_wait", x(0,0,0,1,2'b00,2'b10,1,0));
      chk("irqmw_no_ack", {7'd0, irq_ack}, 8'h00);
      cyc(1, 16'h4144, 1, "irqmw_ready", x(0,1,0,1,2'b00,2'b00,1,0));
      irq = 1'b0;
      cyc(1, 16'h4144, 0, "irqmw_decode2", x(0,0,0,0,2'b00,2'b10,0,0));
      chk("irqmw_decode2_ack", {7'd0, irq_ack}, 8'h00);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wait_controller.md
WAIT_CONTROLLER -- requirements
Module: wait_controller

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: the maximum number of cycles spent in MEMWAIT before a fault.
REQ-002 SHALL have parameter CNT_W, default 4: the wait-counter width, with 2^CNT_W-1 >= TIMEOUT.
REQ-003 SHALL have parameter LINK_REG, default 4'hF: the register written with the link value on interrupt entry.
REQ-004 Ports, as name / direction / width / meaning:
- clk / in / 1 / clock.
- rst / in / 1 / reset, synchronous, active-low.
- instruction / in / 16 / current instruction.
- mem_ready / in / 1 / memory completed the current access.
- oper, func, cond / out / 4 each / decoded fields.
- immediate / out / 8 / instruction[7:0].
- dstaddr, srcaddr / out / 4 each / register addresses.
- alusrca, alusrcb, sign_ext_imm / out / 1 each / datapath selects.
- memread, memwrite, regwrite, pcwrite / out / 1 each / strobes.
- regsrc / out / 2 / writeback source select.
- pcaddrsrc / out / 2 / PC address select.
- busy / out / 1 / high in MEMWAIT.
- fault / out / 1 / sticky memory-timeout flag.

Function
REQ-005 Field decode SHALL be:
- oper=instr[15:12], func=instr[7:4], dstaddr=instr[11:8], srcaddr=instr[3:0].
- cond=instr[3:0] when oper=4 and func=4'hD; otherwise cond=instr[7:4].
REQ-006 Select decode SHALL be:
- alusrca=0 for oper=4'hC, or for oper=4 with func 0 or 8; else 1.
- alusrcb=1 when oper[1:0]!=0, or when oper=8 and func[3:2]=0.
- sign_ext_imm=1 when oper[3:2] is 01 or 10 with oper[1:0]!=0, or when oper is 4'hC or 4'hE.
- regsrc=01 for oper=4 with func=8; 10 for oper=4 with func=0; else 00.
REQ-007 FSM states SHALL be BOOT, DECODE, CALC, MEMWAIT, LOAD, FAULT.
REQ-008 Transitions SHALL be:
- BOOT->DECODE; DECODE->CALC.
- CALC->LOAD when the instruction is a load and mem_ready=1.
- CALC->MEMWAIT when the instruction is a load or store and mem_ready=0.
- CALC->DECODE otherwise.
REQ-009 In MEMWAIT:
- mem_ready=1 moves a load to LOAD and a store to DECODE.
- Otherwise the counter increments; reaching TIMEOUT moves to FAULT.
REQ-010 LOAD->DECODE; FAULT SHALL hold until reset.
REQ-011 memread=1 for a load in CALC and MEMWAIT; memwrite=1 for a store in CALC and MEMWAIT.
REQ-012 pcwrite SHALL be:
- 1 in LOAD.
- 1 for a store in the CALC or MEMWAIT cycle where mem_ready=1.
- 1 for all other instructions in CALC.
- 0 otherwise.
REQ-013 regwrite SHALL be:
- 1 in LOAD.
- 1 in CALC, except for oper 4'hB or 4'hC, oper=0 with func 0 or 4'hB, and oper=4 with func 0, 4, or 4'hC.
- 0 in all other states.
REQ-014 pcaddrsrc SHALL be {!pcwrite, BOOT ? 0 : !alusrca}.
REQ-015 Wait counter behaviour:
- Clears on every CALC entry.
- Saturates at TIMEOUT.
- mem_ready on the same cycle the counter reaches TIMEOUT SHALL take priority over the fault.
REQ-016 fault=1 exactly while in FAULT; all strobes SHALL be 0 in FAULT and BOOT.

Reset
REQ-017 rst=0 at a clk edge SHALL force state BOOT, clear the counter, fault=0 and busy=0, including in the middle of MEMWAIT.
REQ-018 With rst=0, all strobes SHALL be 0 after the edge; the decode outputs remain combinational from instruction.

Configuration
REQ-019 Macro WAITCTL_IRQ_EN defined SHALL add the following ports:
- irq, in, 1, level interrupt request.
- irq_ack, out, 1, vector select.
REQ-020 With the macro defined, behaviour SHALL be:
- irq=1 in DECODE enters state IRQ for one cycle instead of CALC.
- In IRQ: regwrite=1, regsrc=01, dstaddr=LINK_REG, pcwrite=1, irq_ack=1, all other strobes 0; then DECODE.
- irq is never sampled outside DECODE.
REQ-021 Without the macro, the irq, irq_ack and IRQ state SHALL be absent and behaviour SHALL be as in REQ-007 to REQ-016.

Verification
REQ-022 Release rst and hold instruction=0x0355 (add) -> states BOOT, DECODE, CALC; in CALC regwrite=1, pcwrite=1, pcaddrsrc=00, regsrc=00.
REQ-023 Load 0x4207 with mem_ready=1 in CALC -> LOAD in the next cycle with regwrite=1, pcwrite=1, regsrc=10; memread=0 in LOAD.
REQ-024 Store 0x4144 with mem_ready=0 for 3 cycles then 1 -> memwrite=1 for 4 cycles, busy=1 for 3 cycles, pcwrite=1 only on the ready cycle, regwrite=0 throughout.
REQ-025 Load with mem_ready=0 and TIMEOUT=15 -> FAULT after 15 MEMWAIT cycles with fault=1 and strobes 0; rst=0 -> BOOT and fault=0.
REQ-026 With WAITCTL_IRQ_EN, irq=1 in DECODE -> IRQ cycle with irq_ack=1, dstaddr=4'hF, regsrc=01, regwrite=1, pcwrite=1; irq=1 during MEMWAIT is ignored.
